esfa_lookup_engine: RTL and testbench



---
 rtl/esfa_lookup_if.sv | 55 +++++
 rtl/esfa_lookup_engine.sv | 145 ++++++++++++++
 tb/tb_esfa_lookup_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/esfa_lookup_if.sv
`default_nettype none
// ============================================================================
// Module   : esfa_lookup_if
// Purpose  : Request, cell-store read and response bundle of the ESFA lookup
//            engine.
// Revision : 1.0
// ============================================================================
interface esfa_lookup_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_handle;
    logic [DATA_W-1:0] req_index;

    logic              cell_rd_en;
    logic [ADDR_W-1:0] cell_addr;
    logic              cell_arrDef;
    logic              cell_eltDef;
    logic [DATA_W-1:0] cell_array_code;
    logic [DATA_W-1:0] cell_rank;
    logic [DATA_W-1:0] cell_index;
    logic [DATA_W-1:0] cell_value;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_found;
    logic [DATA_W-1:0] rsp_value;
    logic [DATA_W-1:0] rsp_context;
    logic [DATA_W-1:0] rsp_rank;
    logic [ADDR_W-1:0] rsp_addr;

    // Engine side: takes requests, reads the store, produces responses.
    modport master (
        input  req_valid, req_handle, req_index,
        output req_ready,
        output cell_rd_en, cell_addr,
        input  cell_arrDef, cell_eltDef, cell_array_code, cell_rank,
        input  cell_index, cell_value,
        output rsp_valid, rsp_found, rsp_value, rsp_context, rsp_rank, rsp_addr,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_handle, req_index,
        input  req_ready,
        input  cell_rd_en, cell_addr,
        output cell_arrDef, cell_eltDef, cell_array_code, cell_rank,
        output cell_index, cell_value,
        input  rsp_valid, rsp_found, rsp_value, rsp_context, rsp_rank, rsp_addr,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/esfa_lookup_engine.sv
`default_nettype none
// ============================================================================
// Module   : esfa_lookup_engine
// Purpose  : Sequential (handle, index) lookup over the ESFA cell store,
//            returning the lowest-addressed matching cell.
// Revision : 1.0
// ============================================================================
module esfa_lookup_engine #(
    parameter int NUM_CELLS = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    esfa_lookup_if.master  bus
);
    localparam int                c_PTR_W     = ADDR_W + 1;
    localparam logic [c_PTR_W-1:0] c_NUM_CELLS = c_PTR_W'(NUM_CELLS);
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic [DATA_W-1:0]   r_handle;
    logic [DATA_W-1:0]   r_index;
    logic [c_PTR_W-1:0]  r_ptr;
    logic                r_cell_rd_en;
    logic [ADDR_W-1:0]   r_cell_addr;
    logic                r_dv;
    logic [ADDR_W-1:0]   r_cmp_addr;
    logic                r_rsp_valid;
    logic                r_rsp_found;
    logic [DATA_W-1:0]   r_rsp_value;
    logic [DATA_W-1:0]   r_rsp_context;
    logic [DATA_W-1:0]   r_rsp_rank;
    logic [ADDR_W-1:0]   r_rsp_addr;

    logic                w_match;

    // Store data is only meaningful the cycle after a strobed read.
    assign w_match = r_dv && bus.cell_arrDef && bus.cell_eltDef &&
                     (bus.cell_array_code == r_handle) &&
                     (bus.cell_index == r_index);

    // Address 0 is issued on the accept edge so a hit at k answers after E(k+2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_handle      <= '0;
            r_index       <= '0;
            r_ptr         <= '0;
            r_cell_rd_en  <= 1'b0;
            r_cell_addr   <= '0;
            r_dv          <= 1'b0;
            r_cmp_addr    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_found   <= 1'b0;
            r_rsp_value   <= '0;
            r_rsp_context <= '0;
            r_rsp_rank    <= '0;
            r_rsp_addr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_handle     <= bus.req_handle;
                        r_index      <= bus.req_index;
                        r_req_ready  <= 1'b0;
                        r_cell_rd_en <= 1'b1;
                        r_cell_addr  <= '0;
                        r_ptr        <= c_PTR_W'(1);
                        r_dv         <= 1'b0;
                        r_state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_dv       <= r_cell_rd_en;
                    r_cmp_addr <= r_cell_addr;
                    if (w_match) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_found   <= 1'b1;
                        r_rsp_value   <= bus.cell_value;
                        r_rsp_context <= bus.cell_array_code;
                        r_rsp_rank    <= bus.cell_rank;
                        r_rsp_addr    <= r_cmp_addr;
                        r_cell_rd_en  <= 1'b0;
                        r_cell_addr   <= '0;
                        r_dv          <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_dv && (r_cmp_addr == c_LAST_ADDR)) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_found   <= 1'b0;
                        r_rsp_value   <= '0;
                        r_rsp_context <= '0;
                        r_rsp_rank    <= '0;
                        r_rsp_addr    <= '0;
                        r_cell_rd_en  <= 1'b0;
                        r_cell_addr   <= '0;
                        r_dv          <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_ptr < c_NUM_CELLS) begin
                        r_cell_rd_en  <= 1'b1;
                        r_cell_addr   <= r_ptr[ADDR_W-1:0];
                        r_ptr         <= r_ptr + c_PTR_W'(1);
                    end else begin
                        r_cell_rd_en  <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_found   <= 1'b0;
                        r_rsp_value   <= '0;
                        r_rsp_context <= '0;
                        r_rsp_rank    <= '0;
                        r_rsp_addr    <= '0;
                        r_req_ready   <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.cell_rd_en  = r_cell_rd_en;
    assign bus.cell_addr   = r_cell_addr;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_found   = r_rsp_found;
    assign bus.rsp_value   = r_rsp_value;
    assign bus.rsp_context = r_rsp_context;
    assign bus.rsp_rank    = r_rsp_rank;
    assign bus.rsp_addr    = r_rsp_addr;
endmodule
`default_nettype wire

// File: tb/tb_esfa_lookup_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_esfa_lookup_engine
// Purpose  : Directed self-checking bench for esfa_lookup_engine.
// Revision : 1.0
// ============================================================================
module tb_esfa_lookup_engine;
    localparam int NUM_CELLS = 16;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    esfa_lookup_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    esfa_lookup_engine #(
        .NUM_CELLS (NUM_CELLS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Cell store model with a one-cycle synchronous read port.
    logic              m_arr  [NUM_CELLS];
    logic              m_elt  [NUM_CELLS];
    logic [DATA_W-1:0] m_code [NUM_CELLS];
    logic [DATA_W-1:0] m_rank [NUM_CELLS];
    logic [DATA_W-1:0] m_idx  [NUM_CELLS];
    logic [DATA_W-1:0] m_val  [NUM_CELLS];

    always @(posedge clk) begin
        if (bus.cell_rd_en) begin
            bus.cell_arrDef     <= m_arr[bus.cell_addr];
            bus.cell_eltDef     <= m_elt[bus.cell_addr];
            bus.cell_array_code <= m_code[bus.cell_addr];
            bus.cell_rank       <= m_rank[bus.cell_addr];
            bus.cell_index      <= m_idx[bus.cell_addr];
            bus.cell_value      <= m_val[bus.cell_addr];
        end
    end

    int max_addr;
    always @(negedge clk)
        if (bus.cell_rd_en && int'(bus.cell_addr) > max_addr) max_addr = int'(bus.cell_addr);

    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    logic prev_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NUM_CELLS; i++) begin
            m_arr[i] = 1'b0; m_elt[i] = 1'b0; m_code[i] = '0;
            m_rank[i] = '0;  m_idx[i] = '0;   m_val[i] = '0;
        end
    endtask

    task automatic set_cell(input int a, input logic ad, input logic ed, input logic [7:0] code,
                            input logic [7:0] idx, input logic [7:0] val, input logic [7:0] rank);
        m_arr[a] = ad; m_elt[a] = ed; m_code[a] = code;
        m_idx[a] = idx; m_val[a] = val; m_rank[a] = rank;
    endtask

    // Issue a request, then count edges after the accept edge until rsp_valid.
    task automatic run_req(input logic [7:0] h, input logic [7:0] i);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_handle = h; bus.req_index = i;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_handle = ~h; bus.req_index = ~i;
        lat = 0;
        prev_rd = bus.cell_rd_en;
        while (!bus.rsp_valid && lat < 40) begin
            prev_rd = bus.cell_rd_en;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_rsp(input string tag, input int exp_lat, input logic f, input logic [7:0] v,
                             input logic [7:0] c, input logic [7:0] r, input logic [3:0] a);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_found"},   bus.rsp_found, f);
        chk({tag, "_value"},   bus.rsp_value, v);
        chk({tag, "_context"}, bus.rsp_context, c);
        chk({tag, "_rank"},    bus.rsp_rank, r);
        chk({tag, "_addr"},    bus.rsp_addr, a);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk); bus.rsp_ready = 1'b1;
        @(posedge clk); #1; bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_clear"}, bus.rsp_valid, 1'b0);
        chk({tag, "_req_ready_back"},  bus.req_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_handle = '0; bus.req_index = '0;
        bus.rsp_ready = 1'b0;
        max_addr = 0;
        clear_mem();
        repeat (2) @(posedge clk); #1;
        chk("reset_req_ready", bus.req_ready, 1'b1);
        chk("reset_rd_en",     bus.cell_rd_en, 1'b0);
        chk("reset_addr",      bus.cell_addr, 4'd0);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_rsp_found", bus.rsp_found, 1'b0);
        chk("reset_rsp_value", bus.rsp_value, 8'h00);
        @(negedge clk); rst_n = 1'b1;

        // Hit at address 0
        set_cell(0, 1, 1, 8'h05, 8'h03, 8'hAA, 8'h01);
        run_req(8'h05, 8'h03);
        check_rsp("hit0", 2, 1'b1, 8'hAA, 8'h05, 8'h01, 4'd0);
        handshake("hit0");

        // Hit only at the last address
        clear_mem();
        set_cell(15, 1, 1, 8'h22, 8'h07, 8'h5C, 8'h33);
        run_req(8'h22, 8'h07);
        check_rsp("hit15", 17, 1'b1, 8'h5C, 8'h22, 8'h33, 4'd15);
        handshake("hit15");

        // Miss: right code/index but element or array not defined
        clear_mem();
        set_cell(6, 1, 0, 8'h40, 8'h41, 8'h66, 8'h06);
        set_cell(7, 0, 1, 8'h40, 8'h41, 8'h77, 8'h07);
        run_req(8'h40, 8'h41);
        check_rsp("miss", 17, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0);
        chk("miss_rd_en_last_cmp", prev_rd, 1'b0);
        handshake("miss");

        // Duplicate matches: lowest address wins, scan stops early
        clear_mem();
        set_cell(4, 1, 1, 8'h31, 8'h0C, 8'h11, 8'h44);
        set_cell(9, 1, 1, 8'h31, 8'h0C, 8'h99, 8'h49);
        max_addr = 0;
        run_req(8'h31, 8'h0C);
        check_rsp("dup", 6, 1'b1, 8'h11, 8'h31, 8'h44, 4'd4);
        repeat (2) @(posedge clk); #1;
        chk("dup_max_addr", max_addr, 5);
        handshake("dup");

        // Backpressure with a stray request during RESP
        clear_mem();
        set_cell(3, 1, 1, 8'h10, 8'h20, 8'hE7, 8'h42);
        run_req(8'h10, 8'h20);
        check_rsp("bp", 5, 1'b1, 8'hE7, 8'h10, 8'h42, 4'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.req_valid = k[0]; bus.req_handle = 8'h55; bus.req_index = 8'h20;
            @(posedge clk); #1;
            chk("bp_req_ready_low", bus.req_ready, 1'b0);
            chk("bp_rsp_valid_held", bus.rsp_valid, 1'b1);
            chk("bp_value_held", bus.rsp_value, 8'hE7);
        end
        bus.req_valid = 1'b0;
        check_rsp("bp_after", 5, 1'b1, 8'hE7, 8'h10, 8'h42, 4'd3);
        handshake("bp");
        repeat (3) @(posedge clk); #1;
        chk("bp_no_second_rsp", bus.rsp_valid, 1'b0);
        chk("bp_still_idle", bus.req_ready, 1'b1);

        // Reset in the middle of a scan, then a clean lookup
        clear_mem();
        set_cell(2, 1, 1, 8'h77, 8'h12, 8'h3C, 8'h09);
        set_cell(5, 1, 1, 8'h78, 8'h12, 8'h3D, 8'h0A);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_handle = 8'h78; bus.req_index = 8'h12;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_en", bus.cell_rd_en, 1'b0);
        chk("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_mid_rsp_value", bus.rsp_value, 8'h00);
        chk("rst_mid_rsp_addr", bus.rsp_addr, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_req_ready", bus.req_ready, 1'b1);
        repeat (4) @(posedge clk); #1;
        chk("rst_mid_no_rsp", bus.rsp_valid, 1'b0);
        run_req(8'h77, 8'h12);
        check_rsp("post_rst", 4, 1'b1, 8'h3C, 8'h77, 8'h09, 4'd2);
        handshake("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
